// File: rtl/rst_sequencer.sv
// Staged reset release: hold all stages for a settle time, then release them
// one at a time in index order, each waiting on the previous stage's acknowledge.
module rst_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  I_CLK,
    input  logic                  I_RST_N,
    input  logic                  I_SOFT_RST_REQ,
    input  logic [NUM_STAGES-1:0] I_STAGE_ACK,
    output logic [NUM_STAGES-1:0] O_STAGE_RSTN,
    output logic [2:0]            O_CUR_STAGE,
    output logic                  O_ALL_DONE,
    output logic                  O_TIMEOUT_ERR
);

    typedef enum logic [1:0] {HOLD, WAIT_ACK, DONE, ERR} state_t;

    state_t     state;
    logic [9:0] hold_cnt;
    logic [9:0] wait_cnt;
    logic [9:0] hold_inc;
    logic [9:0] wait_inc;
    logic       ack_cur;
    logic       last_stage;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    assign hold_inc   = sat_inc(hold_cnt);
    assign wait_inc   = sat_inc(wait_cnt);
    assign last_stage = (O_CUR_STAGE == 3'(NUM_STAGES - 1));

    // Only the acknowledge of the stage currently waited on is observed.
    always_comb begin
        ack_cur = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (O_CUR_STAGE == 3'(i)) ack_cur = I_STAGE_ACK[i];
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            wait_cnt      <= '0;
            O_STAGE_RSTN  <= '0;
            O_CUR_STAGE   <= '0;
            O_ALL_DONE    <= 1'b0;
            O_TIMEOUT_ERR <= 1'b0;
        end else if (I_SOFT_RST_REQ) begin
            state         <= HOLD;
            hold_cnt      <= '0;
            wait_cnt      <= '0;
            O_STAGE_RSTN  <= '0;
            O_CUR_STAGE   <= '0;
            O_ALL_DONE    <= 1'b0;
            O_TIMEOUT_ERR <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    hold_cnt <= hold_inc;
                    if (hold_inc == 10'(HOLD_CYCLES)) begin
                        O_STAGE_RSTN <= {{(NUM_STAGES-1){1'b0}}, 1'b1};
                        O_CUR_STAGE  <= '0;
                        wait_cnt     <= '0;
                        state        <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // An acknowledge on the timeout edge still wins.
                    if (ack_cur) begin
                        if (last_stage) begin
                            O_ALL_DONE <= 1'b1;
                            state      <= DONE;
                        end else begin
                            O_STAGE_RSTN <= {O_STAGE_RSTN[NUM_STAGES-2:0], 1'b1};
                            O_CUR_STAGE  <= O_CUR_STAGE + 3'd1;
                            wait_cnt     <= '0;
                        end
                    end else begin
                        wait_cnt <= wait_inc;
                        if (wait_inc == 10'(ACK_TIMEOUT)) begin
                            O_TIMEOUT_ERR <= 1'b1;
                            state         <= ERR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: table vectors, hand-written corner sequences and
// randomized stimulus against a release-count reference model.
module tb_rst_sequencer;

    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int TO   = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic [N-1:0] ack = '0;
    logic [N-1:0] rstn_o;
    logic [2:0]   cur_o;
    logic         done_o;
    logic         err_o;

    int errors = 0;
    int checks = 0;

    // Reference model: number of released stages plus elapsed edges.
    int m_rel;
    int m_since;
    bit m_done;
    bit m_err;

    typedef struct {
        int           n;
        logic         r;
        logic [N-1:0] a;
        logic [N-1:0] er;
        logic [2:0]   ec;
        logic         ed;
        logic         ee;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    rst_sequencer #(.NUM_STAGES(N), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TO)) dut (
        .I_CLK          (clk),
        .I_RST_N        (rst_n),
        .I_SOFT_RST_REQ (req),
        .I_STAGE_ACK    (ack),
        .O_STAGE_RSTN   (rstn_o),
        .O_CUR_STAGE    (cur_o),
        .O_ALL_DONE     (done_o),
        .O_TIMEOUT_ERR  (err_o)
    );

    function automatic void model_reset();
        m_rel   = 0;
        m_since = 0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic void model_edge(input logic r, input logic [N-1:0] a);
        if (r) begin
            model_reset();
        end else if (!m_done && !m_err) begin
            if (m_since < 1023) m_since++;
            if (m_rel == 0) begin
                if (m_since == HOLD) begin
                    m_rel   = 1;
                    m_since = 0;
                end
            end else if (a[m_rel-1]) begin
                if (m_rel == N) m_done = 1'b1;
                else begin
                    m_rel++;
                    m_since = 0;
                end
            end else if (m_since == TO) begin
                m_err = 1'b1;
            end
        end
    endfunction

    task automatic check(input string name, input logic [N-1:0] er, input logic [2:0] ec,
                         input logic ed, input logic ee);
        checks++;
        if ({rstn_o, cur_o, done_o, err_o} !== {er, ec, ed, ee}) begin
            errors++;
            $display("FAIL %s @%0t: got rstn=%h cur=%0d done=%b err=%b, want rstn=%h cur=%0d done=%b err=%b",
                     name, $time, rstn_o, cur_o, done_o, err_o, er, ec, ed, ee);
        end
    endtask

    task automatic check_model(input string name);
        logic [N-1:0] er;
        logic [2:0]   ec;
        er = N'((1 << m_rel) - 1);
        ec = (m_rel == 0) ? 3'd0 : 3'(m_rel - 1);
        check(name, er, ec, m_done, m_err);
    endtask

    task automatic step(input logic r, input logic [N-1:0] a);
        req = r;
        ack = a;
        @(posedge clk);
        model_edge(r, a);
        #1;
        check_model("model");
    endtask

    task automatic hard_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", '0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] er;

        // Instant acknowledges, soft restart from DONE, timeout on stage 2,
        // soft restart from ERR with the request held for 10 clocks.
        tbl.push_back('{15, 1'b0, 4'hF, 4'h0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'hF, 4'h1, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'hF, 4'h3, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'hF, 4'h7, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'hF, 4'hF, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'hF, 4'hF, 3'd3, 1'b1, 1'b0});
        tbl.push_back('{5,  1'b0, 4'h0, 4'hF, 3'd3, 1'b1, 1'b0});
        tbl.push_back('{1,  1'b1, 4'hF, 4'h0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{15, 1'b0, 4'hF, 4'h0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'hF, 4'h1, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b1, 4'h3, 4'h0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{15, 1'b0, 4'h3, 4'h0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'h3, 4'h1, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'h3, 4'h3, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'h3, 4'h7, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{7,  1'b0, 4'h3, 4'h7, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'h3, 4'h7, 3'd2, 1'b0, 1'b1});
        tbl.push_back('{50, 1'b0, 4'h3, 4'h7, 3'd2, 1'b0, 1'b1});
        tbl.push_back('{10, 1'b1, 4'h0, 4'h0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{15, 1'b0, 4'hF, 4'h0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1,  1'b0, 4'hF, 4'h1, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{4,  1'b0, 4'hF, 4'hF, 3'd3, 1'b1, 1'b0});

        ack = 4'hF;
        #2;
        check("reset_state", '0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            for (int j = 0; j < tbl[i].n; j++) step(tbl[i].r, tbl[i].a);
            check($sformatf("vec%0d", i), tbl[i].er, tbl[i].ec, tbl[i].ed, tbl[i].ee);
        end

        // Nominal: each acknowledge returned 3 clocks after its release.
        hard_reset();
        for (int n = 1; n <= 30; n++) begin
            a = '0;
            for (int k = 0; k < N; k++) if (n >= 19 + 3 * k) a[k] = 1'b1;
            step(1'b0, a);
            er = (n < 16) ? 4'h0 : (n < 19) ? 4'h1 : (n < 22) ? 4'h3 : (n < 25) ? 4'h7 : 4'hF;
            check($sformatf("nominal_e%0d", n), er,
                  (n < 19) ? 3'd0 : (n < 22) ? 3'd1 : (n < 25) ? 3'd2 : 3'd3,
                  n >= 28, 1'b0);
        end

        // Hard reset while rstn=0x3, then a clean restart from edge 1.
        hard_reset();
        for (int n = 1; n <= 20; n++) begin
            a = '0;
            for (int k = 0; k < N; k++) if (n >= 19 + 3 * k) a[k] = 1'b1;
            step(1'b0, a);
        end
        check("pre_hard_reset", 4'h3, 3'd1, 1'b0, 1'b0);
        hard_reset();
        for (int n = 1; n <= 15; n++) step(1'b0, 4'hF);
        check("restart_e15", 4'h0, 3'd0, 1'b0, 1'b0);
        step(1'b0, 4'hF);
        check("restart_e16", 4'h1, 3'd0, 1'b0, 1'b0);

        // Acknowledge on the exact timeout edge, then a stray stage-3 pulse.
        step(1'b1, 4'h0);
        for (int n = 0; n < HOLD; n++) step(1'b0, 4'h0);
        for (int n = 0; n < TO - 1; n++) step(1'b0, 4'h0);
        step(1'b0, 4'h1);
        check("ack_on_timeout_edge", 4'h3, 3'd1, 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) step(1'b0, 4'h0);
        step(1'b0, 4'h8);
        for (int n = 0; n < 3; n++) step(1'b0, 4'h0);
        check("stray_ack_pre_timeout", 4'h3, 3'd1, 1'b0, 1'b0);
        step(1'b0, 4'h0);
        check("stray_ack_timeout", 4'h3, 3'd1, 1'b0, 1'b1);

        // Randomized stimulus against the reference model.
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step($urandom_range(0, 199) == 0, a);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Staged reset release controller fed by the block-level protected (synchronously deasserted) reset. It holds every downstream stage in reset for a fixed settle time. It then releases stage resets one at a time in index order, waiting for each stage to acknowledge readiness before releasing the next. It reports completion or an acknowledge timeout and supports a software-requested re-sequence without toggling the hard reset.

## Interface
- NUM_STAGES, 4, number of sequenced reset outputs; legal 2..8
- HOLD_CYCLES, 16, clocks all stages stay in reset after sequence start; legal 1..1023
- ACK_TIMEOUT, 255, max clocks to wait for a stage acknowledge; legal 1..1023
- I_CLK  input  1  clock; all logic on rising edge
- I_RST_N  input  1  reset, asynchronous, active-low; clock I_CLK
- I_SOFT_RST_REQ  input  1  synchronous request to restart the sequence, level-sampled
- I_STAGE_ACK  input  NUM_STAGES  per-stage ready acknowledge; bit k belongs to stage k
- O_STAGE_RSTN  output  NUM_STAGES  per-stage active-low reset; 0 = held in reset
- O_CUR_STAGE  output  3  index of the stage currently being released or waited on
- O_ALL_DONE  output  1  all stages released and acknowledged
- O_TIMEOUT_ERR  output  1  sticky: a stage failed to acknowledge in time

## Operation
- States: HOLD, WAIT_ACK, DONE, ERR.
- Reset (I_RST_N=0, asynchronous):
  - Outputs: O_STAGE_RSTN=0, O_CUR_STAGE=0, O_ALL_DONE=0, O_TIMEOUT_ERR=0.
  - State HOLD; hold counter and wait counter cleared.
- HOLD:
  - Hold counter increments each edge.
  - On the edge where it reaches HOLD_CYCLES: O_STAGE_RSTN[0] becomes 1, O_CUR_STAGE=0, wait counter cleared, next state WAIT_ACK.
- WAIT_ACK for stage k, where k = O_CUR_STAGE:
  - Edge samples I_STAGE_ACK[k]=1 and k<NUM_STAGES-1: O_STAGE_RSTN[k+1] becomes 1, O_CUR_STAGE=k+1, wait counter cleared, stay in WAIT_ACK.
  - Edge samples I_STAGE_ACK[k]=1 and k=NUM_STAGES-1: O_ALL_DONE becomes 1, next state DONE.
  - Otherwise the wait counter increments. On the edge where it reaches ACK_TIMEOUT: O_TIMEOUT_ERR becomes 1, next state ERR.
- ERR:
  - Stages 0..k stay released; stages above k stay in reset.
  - O_CUR_STAGE holds the failing index k.
- DONE and ERR are terminal until a soft request or hard reset.
- Acknowledge bits other than bit O_CUR_STAGE are ignored in all states.
- Acknowledge drop after release is ignored; no monitoring in DONE.
- Released stage resets are never re-asserted except by a soft request or hard reset.
- Soft request has priority over all transitions, in every state. On the edge sampling I_SOFT_RST_REQ=1:
  - O_STAGE_RSTN=0, O_ALL_DONE=0, O_TIMEOUT_ERR=0, O_CUR_STAGE=0.
  - Both counters cleared; next state HOLD.
  - While the request is held high the hold counter stays 0. Counting starts on the first edge sampling the request low.
- Counter widths: 10 bits each, saturating; never wrap.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Hard reset release: edges are numbered from the first rising edge with I_RST_N=1 as edge 1. O_STAGE_RSTN[0] rises on edge HOLD_CYCLES.
- Release of stage k occurs on edge E. Acknowledge for stage k is first sampled on edge E+1.
- The acknowledge for stage k is sampled high on edge A. Stage k+1 is released on that same edge A, giving a minimum 1 clock per stage.
- Acknowledge already high when stage k is released: the next stage is released exactly 1 clock later.
- Timeout: I_STAGE_ACK[k] stays low. With stage k released on edge E, O_TIMEOUT_ERR rises on edge E+ACK_TIMEOUT.
- If the acknowledge arrives on the same edge that would time out, the acknowledge wins and there is no error.
- Soft request: outputs change on the edge after the request is sampled. O_STAGE_RSTN[0] rises HOLD_CYCLES edges after the first edge sampling the request low.
- Hard reset mid-sequence takes effect immediately and asynchronously: all outputs go to their reset values.

## Test plan
Benches use NUM_STAGES=4, HOLD_CYCLES=16, ACK_TIMEOUT=8.
- Nominal sequence: release hard reset; each acknowledge is returned 3 clocks after its release. Required response:
  - O_STAGE_RSTN[0] rises at edge 16, then 0x1→0x3→0x7→0xF at 3-clock spacing.
  - O_ALL_DONE=1 at edge 28; O_TIMEOUT_ERR=0.
- Instant acknowledges: I_STAGE_ACK=0xF held from time 0. Required response:
  - Releases occur at edges 16, 17, 18 and 19.
  - O_ALL_DONE rises at edge 20.
- Timeout: stage 2 never acknowledges; stages 0 and 1 acknowledge immediately. Required response:
  - O_TIMEOUT_ERR=1 exactly 8 edges after stage 2 is released.
  - O_STAGE_RSTN=0x7, O_CUR_STAGE=2, O_ALL_DONE=0, all held steady for 50 clocks.
- Soft restart from ERR and from DONE: pulse I_SOFT_RST_REQ for 1 clock. Required response:
  - Next edge: O_STAGE_RSTN=0x0, flags cleared.
  - Full sequence repeats with O_STAGE_RSTN[0] rising 16 edges later.
  - Request held 10 clocks: counting starts only after it drops.
- Hard reset mid-sequence: assert I_RST_N low asynchronously, between clock edges, while O_STAGE_RSTN=0x3. Required response:
  - All outputs go to 0 immediately, with no clock.
  - After release, the sequence restarts from edge 1.
- Boundary and ignore cases:
  - Stage-3 acknowledge pulsed during stage-1 wait: ignored, stage 1 still times out.
  - Acknowledge arriving on the exact timeout edge: no error, sequence continues.
